data_mem_responder: RTL and testbench

//  Data-memory responder for the pipeline's load/store path: answers MEM_READ_EN/MEM_WRITE_EN

---
 rtl/data_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM pipeline stage.
// Byte-addressed RV32 memory with a fixed access latency. A request raises
// MEM_BUSYWAIT in the same cycle and holds it for exactly LATENCY cycles.
// A single DONE cycle then presents the load result and any error pulse.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ_EN,
    input  logic        MEM_WRITE_EN,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        MEM_BUSYWAIT,
    output logic        MEM_ERROR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MEM_BYTES = 1 << ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              func3_q;
    logic [31:0]             wdata_q;
    logic                    store_q;
    logic [31:0]             rdata_q;
    logic                    err_q;
    logic                    busy;
    logic [7:0]              mem_q [0:MEM_BYTES-1];

    // Bits above the decoded address range are ignored, which gives the wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[31:ADDR_WIDTH];

    logic req;
    assign req = MEM_READ_EN | MEM_WRITE_EN;

    // Access operands: the live inputs when a LATENCY=1 access completes
    // straight from IDLE, otherwise the copy latched at request time.
    logic                  live;
    logic [ADDR_WIDTH-1:0] acc_addr, acc_a1, acc_a2, acc_a3;
    logic [2:0]            acc_f3;
    logic [31:0]           acc_wdata;
    logic                  acc_store;

    assign live      = (state_q == S_IDLE);
    assign acc_addr  = live ? ADDRESS[ADDR_WIDTH-1:0] : addr_q;
    assign acc_f3    = live ? FUNC3 : func3_q;
    assign acc_wdata = live ? WRITE_DATA : wdata_q;
    assign acc_store = live ? MEM_WRITE_EN : store_q;
    assign acc_a1    = acc_addr + ADDR_WIDTH'(1);
    assign acc_a2    = acc_addr + ADDR_WIDTH'(2);
    assign acc_a3    = acc_addr + ADDR_WIDTH'(3);

    // The access fires on the edge that enters DONE; gated by RESET so a
    // reset held across an edge can never commit a write.
    logic do_access;
    assign do_access = RESET &
                       (((state_q == S_IDLE) && req && (LATENCY == 1)) ||
                        ((state_q == S_BUSY) && (cnt_q == 4'd1)));

    // Alignment / legal-code decode and little-endian load assembly.
    logic        fault;
    logic        misaligned;
    logic [31:0] load_val;
    logic [7:0]  b0, b1, b2, b3;

    assign b0 = mem_q[acc_addr];
    assign b1 = mem_q[acc_a1];
    assign b2 = mem_q[acc_a2];
    assign b3 = mem_q[acc_a3];

    // Decode fault conditions and build the extended load value.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        misaligned = 1'b0;
        fault      = 1'b0;
        load_val   = 32'd0;
        case (acc_f3[1:0])
            2'b01:   misaligned = acc_addr[0];
            2'b10:   misaligned = |acc_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (acc_store) begin
            fault = (acc_f3 >= 3'b011) | misaligned;
        end else begin
            fault = (acc_f3[1:0] == 2'b11) | (acc_f3 == 3'b110) | misaligned;
            case (acc_f3)
                3'b000:  load_val = {{24{b0[7]}}, b0};
                3'b100:  load_val = {24'd0, b0};
                3'b001:  load_val = {{16{b1[7]}}, b1, b0};
                3'b101:  load_val = {16'd0, b1, b0};
                3'b010:  load_val = {b3, b2, b1, b0};
                default: load_val = 32'd0;
            endcase
        end
    end

    // State, counter, request latch and result registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            func3_q <= 3'd0;
            wdata_q <= 32'd0;
            store_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == S_IDLE) && req) begin
                addr_q  <= ADDRESS[ADDR_WIDTH-1:0];
                func3_q <= FUNC3;
                wdata_q <= WRITE_DATA;
                store_q <= MEM_WRITE_EN;
            end
            if (do_access) begin
                err_q <= fault;
                if (!acc_store) begin
                    rdata_q <= fault ? 32'd0 : load_val;
                end
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    // Backing store writes; only a non-faulting store touches the array.
    // NOTE: the memory array has no reset, so its contents survive RESET.
    always_ff @(posedge CLK) begin
        if (do_access && acc_store && !fault) begin
            mem_q[acc_addr] <= acc_wdata[7:0];
            if (acc_f3[1:0] != 2'b00) begin
                mem_q[acc_a1] <= acc_wdata[15:8];
            end
            if (acc_f3[1:0] == 2'b10) begin
                mem_q[acc_a2] <= acc_wdata[23:16];
                mem_q[acc_a3] <= acc_wdata[31:24];
            end
        end
    end

    // Next-state and busywait decode: IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = req;
                if (req) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign MEM_BUSYWAIT = busy & RESET;
    assign READ_DATA    = rdata_q;
    assign MEM_ERROR    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=4 instance driven from a
// vector table plus hand sequences, and a LATENCY=1 instance for wrap checks.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        rd_en, wr_en;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        busy, err;

    logic        l1_rd_en, l1_wr_en;
    logic [2:0]  l1_f3;
    logic [31:0] l1_addr, l1_wdata, l1_rdata;
    logic        l1_busy, l1_err;

    int n_pass;
    int n_total;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut (
        .CLK(clk), .RESET(rst_n),
        .MEM_READ_EN(rd_en), .MEM_WRITE_EN(wr_en), .FUNC3(f3),
        .ADDRESS(addr), .WRITE_DATA(wdata), .READ_DATA(rdata),
        .MEM_BUSYWAIT(busy), .MEM_ERROR(err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
        .CLK(clk), .RESET(rst_n),
        .MEM_READ_EN(l1_rd_en), .MEM_WRITE_EN(l1_wr_en), .FUNC3(l1_f3),
        .ADDRESS(l1_addr), .WRITE_DATA(l1_wdata), .READ_DATA(l1_rdata),
        .MEM_BUSYWAIT(l1_busy), .MEM_ERROR(l1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Count busywait-high cycles on the LATENCY=4 instance, sampled at negedges.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_access(input logic w, input logic r, input logic [2:0] fc,
                              input logic [31:0] a, input logic [31:0] d,
                              output int n, output logic [31:0] rv,
                              output logic e_done, output logic e_after);
        @(negedge clk);
        wr_en = w; rd_en = r; f3 = fc; addr = a; wdata = d;
        #1;
        count_busy(n);
        rv     = rdata;
        e_done = err;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        @(negedge clk);
        e_after = err;
    endtask

    task automatic l1_access(input logic w, input logic r, input logic [2:0] fc,
                             input logic [31:0] a, input logic [31:0] d,
                             output int n, output logic [31:0] rv, output logic e_done);
        @(negedge clk);
        l1_wr_en = w; l1_rd_en = r; l1_f3 = fc; l1_addr = a; l1_wdata = d;
        #1;
        n = 0;
        while (l1_busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        rv       = l1_rdata;
        e_done   = l1_err;
        l1_wr_en = 1'b0;
        l1_rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          n;
        logic [31:0] rv;
        logic        ed, ea;

        n_pass  = 0;
        n_total = 0;
        rd_en = 1'b0; wr_en = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        l1_rd_en = 1'b0; l1_wr_en = 1'b0; l1_f3 = 3'd0; l1_addr = 32'd0; l1_wdata = 32'd0;
        rst_n = 1'b0;

        //                wr    rd    f3      addr        wdata          exp_rd        err
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h020, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h021, 32'h12345680, 32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b000, 32'h021, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b100, 32'h021, 32'h0,        32'h00000080, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 32'h020, 32'h0,        32'hFFFF80A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b101, 32'h020, 32'h0,        32'h000080A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h020, 32'h0,        32'hA5A580A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h012, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h013, 32'h0000FFFF, 32'h00000000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h022, 32'h1234BEEF, 32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h020, 32'h0,        32'hBEEF80A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 32'h022, 32'h0,        32'hFFFFBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b101, 32'h022, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b011, 32'h020, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b110, 32'h020, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b011, 32'h020, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b100, 32'h020, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h020, 32'h0,        32'hBEEF80A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b000, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b010, 32'h030, 32'h13579BDF, 32'hFFFFFFDE, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h030, 32'h0,        32'h13579BDF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h410, 32'h0,        32'hDEADBEEF, 1'b0});

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        // Table-driven accesses on the LATENCY=4 instance.
        foreach (vecs[i]) begin
            run_access(vecs[i].wr, vecs[i].rd, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       n, rv, ed, ea);
            check($sformatf("v%0d_busy_cycles", i), n, 32'd4);
            check($sformatf("v%0d_rdata", i), rv, vecs[i].exp_rd);
            check($sformatf("v%0d_err_done", i), {31'd0, ed}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_err_after", i), {31'd0, ea}, 32'd0);
        end

        // Reset mid-BUSY: aborts a pending store of zero to 0x20; requester keeps enable high.
        @(negedge clk);
        wr_en = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, n, rv, ed, ea);
        check("midreset_nowrite", rv, 32'hBEEF80A5);
        check("midreset_busy_cycles", n, 32'd4);

        // Back-to-back loads with the enable held straight through DONE.
        @(negedge clk);
        rd_en = 1'b1; f3 = 3'b010; addr = 32'h10;
        #1;
        count_busy(n);
        check("b2b_first_cycles", n, 32'd4);
        check("b2b_first_rdata", rdata, 32'hDEADBEEF);
        addr = 32'h20;
        @(negedge clk);
        check("b2b_second_starts", {31'd0, busy}, 32'd1);
        count_busy(n);
        check("b2b_second_cycles", n, 32'd4);
        check("b2b_second_rdata", rdata, 32'hBEEF80A5);
        rd_en = 1'b0;
        @(negedge clk);
        check("b2b_no_extra_1", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_no_extra_2", {31'd0, busy}, 32'd0);
        check("b2b_rdata_hold", rdata, 32'hBEEF80A5);

        // LATENCY=1 instance: single busy cycle and address wrap at ADDR_WIDTH=10.
        l1_access(1'b1, 1'b0, 3'b010, 32'h3FC, 32'hCAFEF00D, n, rv, ed);
        check("l1_sw_cycles", n, 32'd1);
        check("l1_sw_rdata", rv, 32'd0);
        l1_access(1'b0, 1'b1, 3'b010, 32'h3FC, 32'h0, n, rv, ed);
        check("l1_lw_3fc_cycles", n, 32'd1);
        check("l1_lw_3fc", rv, 32'hCAFEF00D);
        l1_access(1'b0, 1'b1, 3'b010, 32'h7FC, 32'h0, n, rv, ed);
        check("l1_lw_7fc", rv, 32'hCAFEF00D);
        l1_access(1'b0, 1'b1, 3'b000, 32'h7FF, 32'h0, n, rv, ed);
        check("l1_lb_7ff", rv, 32'hFFFFFFCA);
        l1_access(1'b0, 1'b1, 3'b001, 32'h3FD, 32'h0, n, rv, ed);
        check("l1_lh_misaligned_rdata", rv, 32'd0);
        check("l1_lh_misaligned_err", {31'd0, ed}, 32'd1);
        check("l1_err_cleared", {31'd0, l1_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
